// File: rtl/music_sequencer.sv
// music_sequencer: plays {tune, duration} entries from a song ROM with optional inter-note gap, pause, stop and looping
module music_sequencer #(
    parameter int BEAT_CYCLES = 3_125_000,
    parameter int GAP_CYCLES  = 250_000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        tune,
    output logic              busy,
    output logic              note_strobe,
    output logic              done
);

    localparam int BW = BEAT_CYCLES > 1 ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        tune_r, tune_n;
    logic [7:0]        units, units_n;
    logic [BW-1:0]     beat, beat_n;
    logic [GW-1:0]     gap, gap_n;
    logic              strobe_n, done_n;

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_addr    <= '0;
            tune_r      <= '0;
            units       <= '0;
            beat        <= '0;
            gap         <= '0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            rom_addr    <= addr_n;
            tune_r      <= tune_n;
            units       <= units_n;
            beat        <= beat_n;
            gap         <= gap_n;
            note_strobe <= strobe_n;
            done        <= done_n;
        end
    end

    // next-state and counter update; stop overrides everything else
    always_comb begin
        state_n  = state;
        addr_n   = rom_addr;
        tune_n   = tune_r;
        units_n  = units;
        beat_n   = beat;
        gap_n    = gap;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    addr_n  = '0;
                end
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                if (rom_data[7:0] == 8'd0) begin
                    if (loop_en) begin
                        addr_n  = '0;
                        state_n = FETCH;
                    end else begin
                        addr_n  = '0;
                        tune_n  = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    tune_n   = rom_data[15:8];
                    units_n  = rom_data[7:0];
                    beat_n   = '0;
                    strobe_n = 1'b1;
                    state_n  = PLAY;
                end
            end
            PLAY: begin
                if (!pause) begin
                    if (beat == BEAT_LAST) begin
                        beat_n  = '0;
                        units_n = units - 8'd1;
                        if (units == 8'd1) begin
                            if (GAP_CYCLES == 0) begin
                                addr_n  = rom_addr + 1'b1;
                                state_n = FETCH;
                            end else begin
                                tune_n  = '0;
                                gap_n   = '0;
                                state_n = GAP;
                            end
                        end
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            GAP: begin
                if (!pause) begin
                    if (gap == GAP_LAST) begin
                        gap_n   = '0;
                        addr_n  = rom_addr + 1'b1;
                        state_n = FETCH;
                    end else begin
                        gap_n = gap + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (stop) begin
            state_n  = IDLE;
            addr_n   = '0;
            tune_n   = '0;
            units_n  = '0;
            beat_n   = '0;
            gap_n    = '0;
            strobe_n = 1'b0;
            done_n   = 1'b0;
        end
    end

    assign busy = state != IDLE;
    assign tune = (pause && (state == PLAY || state == GAP)) ? 8'h00 : tune_r;

endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: randomized and directed playback checked against a song-level timeline model
module tb_music_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int AW   = 4;
    localparam int MAXC = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [7:0]    tune;
    logic          busy, note_strobe, done;

    logic [15:0]   rom [16];
    int            checks = 0;
    int            failures = 0;
    logic [7:0]    e_tune [MAXC];
    logic          e_busy [MAXC];
    logic          e_stb  [MAXC];
    logic          e_done [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [7:0]    o_tune [MAXC];
    int            done_cyc, stb_cnt, t;

    music_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data), .tune(tune),
        .busy(busy), .note_strobe(note_strobe), .done(done)
    );

    always #5 clk = ~clk;

    // synchronous song ROM
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_p(input int c, input int ps, input int pe);
        return c >= ps && c < pe;
    endfunction

    task automatic emit(input logic [7:0] tn, input logic b, input logic s, input logic d, input logic [AW-1:0] a);
        if (t < MAXC) begin
            e_tune[t] = tn;
            e_busy[t] = b;
            e_stb[t]  = s;
            e_done[t] = d;
            e_addr[t] = a;
        end
        t++;
    endtask

    // expected per-cycle outputs for a song started at cycle 0
    task automatic build(input int n, input bit lp, input int ps, input int pe, input int sc);
        int a, rem;
        bit first, p;
        logic [7:0] prev, code, d;
        for (int i = 0; i < MAXC; i++) begin
            e_tune[i] = 0; e_busy[i] = 0; e_stb[i] = 0; e_done[i] = 0; e_addr[i] = 0;
        end
        t = 0;
        emit(0, 0, 0, 0, 0);
        a = 0;
        prev = 0;
        while (t < n) begin
            emit(prev, 1, 0, 0, AW'(a));
            emit(prev, 1, 0, 0, AW'(a));
            code = rom[a][15:8];
            d = rom[a][7:0];
            if (d == 0) begin
                if (lp) begin
                    a = 0;
                    continue;
                end
                emit(0, 0, 0, 1, 0);
                break;
            end
            rem = d * BEAT;
            first = 1;
            while (rem > 0 && t < n) begin
                p = in_p(t, ps, pe);
                emit(p ? 8'h00 : code, 1, first, 0, AW'(a));
                if (!p) rem--;
                first = 0;
            end
            rem = GAP;
            while (rem > 0 && t < n) begin
                p = in_p(t, ps, pe);
                emit(0, 1, 0, 0, AW'(a));
                if (!p) rem--;
            end
            prev = GAP > 0 ? 8'h00 : code;
            a = (a + 1) % 16;
        end
        if (sc >= 0)
            for (int c = sc + 1; c < MAXC; c++) begin
                e_tune[c] = 0; e_busy[c] = 0; e_stb[c] = 0; e_done[c] = 0; e_addr[c] = 0;
            end
    endtask

    task automatic run(input string nm, input int n, input bit lp, input int ps, input int pe,
                       input int sc, input int xs, input bit cl);
        build(n, lp, ps, pe, sc);
        done_cyc = -1;
        stb_cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start   = (c == 0) || (c == xs && (e_busy[c] || c == sc));
            stop    = (c == sc);
            pause   = in_p(c, ps, pe);
            loop_en = lp;
            @(negedge clk);
            o_tune[c] = tune;
            if (done && done_cyc < 0) done_cyc = c;
            if (note_strobe) stb_cnt++;
            chk($sformatf("%s tune@%0d", nm, c), tune, e_tune[c]);
            chk($sformatf("%s busy@%0d", nm, c), busy, e_busy[c]);
            chk($sformatf("%s strobe@%0d", nm, c), note_strobe, e_stb[c]);
            chk($sformatf("%s done@%0d", nm, c), done, e_done[c]);
            chk($sformatf("%s addr@%0d", nm, c), rom_addr, e_addr[c]);
        end
        if (cl) begin
            @(posedge clk);
            #1;
            start = 0; pause = 0; loop_en = 0; stop = 1;
            @(posedge clk);
            #1;
            stop = 0;
        end
    endtask

    task automatic song1();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2103;
        rom[1] = 16'h2502;
        rom[2] = 16'h0000;
    endtask

    initial begin
        int ps, sc, m;
        song1();
        #12;
        chk("rst tune", tune, 0);
        chk("rst busy", busy, 0);
        chk("rst strobe", note_strobe, 0);
        chk("rst done", done, 0);
        chk("rst addr", rom_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        run("s1", 40, 0, 1000, 1000, -1, -1, 1);
        chk("s1 done_cycle", done_cyc, 31);
        chk("s1 strobes", stb_cnt, 2);
        chk("s1 tune3", o_tune[3], 8'h21);
        chk("s1 tune14", o_tune[14], 8'h21);
        chk("s1 tune15", o_tune[15], 8'h00);
        chk("s1 tune19", o_tune[19], 8'h25);

        run("loop", 60, 1, 1000, 1000, -1, 5, 1);
        chk("loop nodone", done_cyc, 32'hffffffff);
        chk("loop tune33", o_tune[33], 8'h21);

        run("pause", 40, 0, 6, 11, -1, -1, 1);
        chk("pause tune8", o_tune[8], 8'h00);
        chk("pause tune19", o_tune[19], 8'h21);
        chk("pause tune20", o_tune[20], 8'h00);

        run("stop", 20, 0, 1000, 1000, 8, 8, 1);

        for (int i = 0; i < 16; i++) rom[i] = {4'(i % 3 + 1), 4'(i % 7 + 1), 8'd1};
        run("wrap", 140, 0, 1000, 1000, -1, -1, 1);
        chk("wrap tune131", o_tune[131], rom[0][15:8]);

        song1();
        run("prerst", 10, 0, 1000, 1000, -1, -1, 0);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("arst tune", tune, 0);
        chk("arst busy", busy, 0);
        chk("arst strobe", note_strobe, 0);
        chk("arst done", done, 0);
        chk("arst addr", rom_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        run("postrst", 40, 0, 1000, 1000, -1, -1, 1);
        chk("postrst tune3", o_tune[3], 8'h21);

        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 16; i++)
                rom[i] = {($urandom_range(0, 4) == 0) ? 8'h00 : {4'($urandom_range(1, 3)), 4'($urandom_range(1, 7))},
                          8'($urandom_range(1, 3))};
            m = $urandom_range(1, 16);
            if (m < 16) rom[m] = 16'h0000;
            ps = $urandom_range(3, 60);
            sc = $urandom_range(0, 1) ? $urandom_range(5, 100) : -1;
            run($sformatf("rnd%0d", k), 120, 1'($urandom_range(0, 1)), ps, ps + $urandom_range(0, 8),
                sc, $urandom_range(1, 100), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Melody sequencer driving the buzzer tune decoder in the APU. Reads a song from a synchronous ROM, one {tune code, duration} entry per address. Presents each tune code for its programmed length, with an optional silent articulation gap between notes. Supports start, stop, pause and looping under game-logic control. Its `tune` output connects directly to the decoder's 8-bit tune input: high nibble is octave 1..3, low nibble is note 1..7, and 0x00 is silence.

## Interface
- `BEAT_CYCLES`, default 3_125_000: clock cycles per duration unit (1/16 s at 50 MHz). Must be ≥ 1.
- `GAP_CYCLES`, default 250_000: silent cycles inserted after each note. 0 disables the gap.
- `ADDR_W`, default 8: ROM address width.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins playback at address 0 when idle.
- `stop` input 1: one-cycle pulse; aborts playback.
- `pause` input 1: level; freezes timing and mutes output while high.
- `loop_en` input 1: level; when high, an end marker restarts the song at address 0.
- `rom_addr` output ADDR_W: registered song ROM address.
- `rom_data` input 16: ROM word, valid one cycle after `rom_addr`. Bits [15:8] are the tune code; bits [7:0] are the duration in units, where 0 is the end marker.
- `tune` output 8: tune code to the decoder.
- `busy` output 1: high from the cycle after an accepted `start` until return to IDLE.
- `note_strobe` output 1: one-cycle pulse on the first PLAY cycle of each note.
- `done` output 1: one-cycle pulse when a non-looping song ends.

## Operation
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, FETCH, LATCH, PLAY, GAP.
- **IDLE**
  - `tune`=0, `busy`=0, `rom_addr`=0.
  - `start`=1 → FETCH.
- **FETCH**
  - `rom_addr` is stable; lasts one cycle → LATCH.
- **LATCH**
  - Samples `rom_data`.
  - Duration 0 with `loop_en`=1: `rom_addr`←0, → FETCH.
  - Duration 0 with `loop_en`=0: → IDLE and pulse `done`.
  - Otherwise: `tune`←code, unit counter←duration, beat counter←0, → PLAY.
- **PLAY**
  - Beat counter runs 0..BEAT_CYCLES-1; on wrap, the unit counter decrements.
  - When the last unit completes: → GAP, or → FETCH with `rom_addr`+1 if `GAP_CYCLES`=0.
- **GAP**
  - `tune`=0 for GAP_CYCLES cycles, then `rom_addr`+1 and → FETCH.
- Tune behaviour:
  - With no gap, `tune` holds the previous code through FETCH/LATCH, so consecutive notes stay legato.
  - A code of 0x00 with nonzero duration is a timed rest.
- Address wrap: incrementing past 2^ADDR_W-1 wraps to 0, with no error.
- **Pause** (PLAY/GAP only)
  - Counters hold and `tune` is forced to 0 combinationally from the registered value.
  - On deassert, the note resumes with its remaining time.
  - In FETCH/LATCH, `pause` has no effect; the freeze takes hold on entering PLAY.
- **Stop**
  - From any state, the next state is IDLE: `tune`=0, `busy`=0, `rom_addr`=0, no `done`.
  - `stop` has priority over `start` in the same cycle.
  - `stop` overrides `pause`.
- `start` while `busy`=1 is ignored and does not restart the song.
- Counter widths:
  - Beat counter is clog2(BEAT_CYCLES) bits; unit counter is 8 bits; gap counter is clog2(GAP_CYCLES+1) bits.
  - No product is formed, so there is no overflow.

## Timing
- `start` at cycle 0 → FETCH at cycle 1 → LATCH at cycle 2 → first PLAY cycle at cycle 3.
  - `tune` and `note_strobe` are valid at cycle 3.
  - `busy`=1 from cycle 1.
- Per-note period is 2 + duration·BEAT_CYCLES + GAP_CYCLES cycles, excluding pause time.
  - PLAY is exactly duration·BEAT_CYCLES cycles.
- End marker: `done` is high for the one cycle in which the state is IDLE after LATCH; `busy` falls in that same cycle.
  - With `loop_en`, the marker costs 2 cycles (FETCH+LATCH) before re-fetching address 0.
- `loop_en` is sampled only in LATCH.
- `rst_n` asserted mid-note: outputs clear immediately (asynchronous), with no glitch pulse on `done` or `note_strobe`.

## Test plan
Bench settings: BEAT_CYCLES=4, GAP_CYCLES=2, ADDR_W=4.
- ROM {0x2103, 0x2502, 0x0000}, `start` at cycle 0 → `tune`=0x21 for cycles 3–14, 0 for 15–16; `tune`=0x25 for cycles 19–26; `done` pulse at cycle 31; two `note_strobe` pulses.
- Same ROM with `loop_en`=1 → after the marker, 0x21 reappears 4 cycles after the second gap ends; `done` never asserts; `busy` stays 1.
- `pause` high for 5 cycles starting at cycle 6 → `tune`=0 during the pause; the 0x21 note ends at cycle 19 instead of 14.
- `stop` and `start` asserted together at cycle 8 → IDLE at cycle 9; `tune`=0, `busy`=0, `rom_addr`=0, `done`=0.
- ROM with 16 non-zero entries and no marker → `rom_addr` wraps from 15 to 0 and playback continues.
- `rst_n` low for one cycle at cycle 10 → all outputs 0 immediately; a later `start` replays from address 0 with the cycle-3 latency.
